// File: rtl/fft_stream_if.sv
// fft_stream_if: handshake and control bundle between upstream, fft_stream_ctrl and the FFT datapath
// Ports: in_valid/in_sop (upstream beat), in_ready, dp_en, sw_sel/tw_addr (CW bits),
// out_valid/out_sop/out_eop (aligned output tags), busy, err.
// master = upstream/datapath side, slave = controller side.
interface fft_stream_if #(
  parameter int CW = 4
);
  logic in_valid, in_sop, in_ready, dp_en;
  logic [CW-1:0] sw_sel, tw_addr;
  logic out_valid, out_sop, out_eop, busy, err;
  modport master (
    output in_valid, in_sop,
    input  in_ready, dp_en, sw_sel, tw_addr, out_valid, out_sop, out_eop, busy, err
  );
  modport slave (
    input  in_valid, in_sop,
    output in_ready, dp_en, sw_sel, tw_addr, out_valid, out_sop, out_eop, busy, err
  );
endinterface

// File: rtl/fft_stream_ctrl.sv
// fft_stream_ctrl: beat sequencer for the 4-parallel FFT datapath
// Frames of 2^(LOG2N-2) beats start on in_sop. Drives the datapath enable, commutator selects
// and twiddle address, and carries {valid,sop,eop} tags through a LAT-deep pipe that only
// moves with dp_en, so output tags line up with datapath results.
// Ports: clk, rst (synchronous, active-high), s (fft_stream_if.slave).
// Optional: define FFT_SOP_RESYNC_EN to let a mid-frame sop abort the frame and set sticky err.
module fft_stream_ctrl #(
  parameter int LOG2N = 6,
  parameter int LAT   = 8
) (
  input logic clk,
  input logic rst,
  fft_stream_if.slave s
);
  localparam int CW = LOG2N - 2;
  localparam int DW = $clog2(LAT + 1);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, idx, rev;
  logic [DW-1:0] drn_q, drn_d;
  logic [LAT-1:0][2:0] pipe_q, pipe_d, pipe_k;
  logic rdy, en, en_q, acc, resync;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    drn_d = drn_q;
    rdy = 1'b0;
    en = 1'b0;
    acc = 1'b0;
    resync = 1'b0;
    idx = cnt_q;
    rev = '0;
    case (state_q)
      IDLE: begin
        rdy = 1'b1;
        acc = s.in_valid && s.in_sop;
      end
      RUN: begin
        rdy = 1'b1;
        if (cnt_q != '0) begin
          acc = s.in_valid;
`ifdef FFT_SOP_RESYNC_EN
          resync = s.in_valid && s.in_sop;
`endif
        end else if (s.in_valid) acc = s.in_sop;
        else begin
          // draining starts on the boundary cycle itself so the output stream has no hole
          en = 1'b1;
          drn_d = DW'(LAT);
          state_d = DRAIN;
        end
      end
      default: begin
        en = 1'b1;
        drn_d = drn_q - 1'b1;
        if (drn_q == DW'(1)) state_d = IDLE;
      end
    endcase
    if (resync) idx = '0;
    if (acc) begin
      en = 1'b1;
      cnt_d = idx + 1'b1;
      state_d = RUN;
    end
    for (int k = 0; k < CW; k++) rev[k] = idx[CW-1-k];
    // a resync wipes every in-flight tag so no partial frame reaches the output
    pipe_k = resync ? '0 : pipe_q;
    pipe_d = en ? (3*LAT)'({pipe_k, acc, acc && idx == '0, acc && idx == '1}) : pipe_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      drn_q <= '0;
      pipe_q <= '0;
      en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      drn_q <= drn_d;
      pipe_q <= pipe_d;
      en_q <= en;
    end
  end
`ifdef FFT_SOP_RESYNC_EN
  logic err_q, err_d;
  assign err_d = err_q | resync;
  always_ff @(posedge clk) err_q <= rst ? 1'b0 : err_d;
  assign s.err = err_q;
`else
  assign s.err = 1'b0;
`endif
  assign s.in_ready = rdy && !rst;
  assign s.dp_en = en && !rst;
  assign s.sw_sel = rev;
  assign s.tw_addr = rev;
  // tail tag is only presented after a cycle in which the datapath actually advanced
  assign s.out_valid = en_q && pipe_q[LAT-1][2];
  assign s.out_sop = en_q && pipe_q[LAT-1][1];
  assign s.out_eop = en_q && pipe_q[LAT-1][0];
  assign s.busy = state_q != IDLE;
endmodule

// File: tb/tb_fft_stream_ctrl.sv
// tb_fft_stream_ctrl: directed and randomized check of fft_stream_ctrl against a tag-age reference model
`timescale 1ns/1ps
module tb_fft_stream_ctrl;
  localparam int LOG2N = 6;
  localparam int LAT = 8;
  localparam int CW = LOG2N - 2;
  localparam int NB = 1 << CW;
`ifdef FFT_SOP_RESYNC_EN
  localparam bit RS = 1'b1;
`else
  localparam bit RS = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  fft_stream_if #(.CW(CW)) bus ();
  fft_stream_ctrl #(.LOG2N(LOG2N), .LAT(LAT)) dut (.clk(clk), .rst(rst), .s(bus));
  typedef struct {
    int age;
    bit sop;
    bit eop;
  } tag_t;
  tag_t fly[$];
  int m_mode, m_cnt, m_drn, n_chk, n_fail, n_out;
  bit m_ov, m_os, m_oe, m_err;
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // one clock: drive inputs, check against the model mid-cycle, then advance the model
  task automatic step(bit r, bit v, bit sp);
    bit acc, en, rs;
    int idx, rv;
    rst = r;
    bus.in_valid = v;
    bus.in_sop = sp;
    @(negedge clk);
    acc = 0;
    en = 0;
    rs = 0;
    idx = m_cnt;
    if (!r) begin
      if (m_mode == 0) acc = v && sp;
      else if (m_mode == 1) begin
        if (m_cnt != 0) begin
          acc = v;
          rs = RS && v && sp;
        end else if (v) acc = sp;
        else en = 1;
      end else en = 1;
    end
    if (rs) idx = 0;
    en = en || acc;
    rv = 0;
    for (int k = 0; k < CW; k++) if ((idx >> k) & 1) rv += 1 << (CW - 1 - k);
    chk("in_ready", bus.in_ready, !r && m_mode != 2);
    chk("dp_en", bus.dp_en, en);
    if (acc) begin
      chk("sw_sel", bus.sw_sel, rv);
      chk("tw_addr", bus.tw_addr, rv);
    end
    chk("out_valid", bus.out_valid, m_ov);
    chk("out_sop", bus.out_sop, m_os);
    chk("out_eop", bus.out_eop, m_oe);
    chk("busy", bus.busy, m_mode != 0);
    chk("err", bus.err, m_err);
    if (bus.out_valid === 1'b1) n_out++;
    @(posedge clk);
    if (r) begin
      m_mode = 0;
      m_cnt = 0;
      m_drn = 0;
      fly.delete();
      {m_ov, m_os, m_oe, m_err} = '0;
    end else begin
      {m_ov, m_os, m_oe} = '0;
      if (en) begin
        if (rs) fly.delete();
        for (int i = 0; i < fly.size(); i++) fly[i].age++;
        if (acc) fly.push_back('{1, idx == 0, idx == NB - 1});
        if (fly.size() > 0 && fly[0].age == LAT) begin
          m_ov = 1;
          m_os = fly[0].sop;
          m_oe = fly[0].eop;
          void'(fly.pop_front());
        end
      end
      if (acc) begin
        m_mode = 1;
        m_cnt = (idx + 1) % NB;
      end else if (m_mode == 1 && m_cnt == 0 && !v) begin
        m_mode = 2;
        m_drn = LAT;
      end else if (m_mode == 2) begin
        if (m_drn == 1) m_mode = 0;
        m_drn--;
      end
      m_err = m_err | rs;
    end
    #1;
  endtask
  task automatic frame();
    for (int i = 0; i < NB; i++) step(0, 1, i == 0);
  endtask
  task automatic idle();
    repeat (LAT + 4) step(0, 0, 0);
  endtask
  initial begin
    bus.in_valid = 0;
    bus.in_sop = 0;
    @(posedge clk);
    #1;
    repeat (2) step(1, 0, 0);
    n_out = 0;
    frame();
    idle();
    chk("single_frame_outputs", n_out, NB);
    n_out = 0;
    frame();
    frame();
    idle();
    chk("b2b_frame_outputs", n_out, 2 * NB);
    n_out = 0;
    for (int i = 0; i < NB; i++) begin
      step(0, 1, i == 0);
      if (i == 5) repeat (3) step(0, 0, 0);
    end
    idle();
    chk("gap_frame_outputs", n_out, NB);
    n_out = 0;
    repeat (4) step(0, 1, 0);
    chk("dropped_beats_outputs", n_out, 0);
    frame();
    idle();
    chk("after_drop_outputs", n_out, NB);
    for (int i = 0; i < 11; i++) step(0, 1, i == 0);
    step(1, 1, 0);
    n_out = 0;
    repeat (LAT + 2) step(0, 0, 0);
    chk("post_reset_silent", n_out, 0);
    frame();
    idle();
    chk("post_reset_outputs", n_out, NB);
    n_out = 0;
    for (int i = 0; i < 7; i++) step(0, 1, i == 0);
    frame();
    idle();
    chk("resync_outputs", n_out, NB);
    chk("err_sticky", bus.err, RS);
    repeat (800) step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
